// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline, plus
// a data-memory wait FSM with a timeout counter and a sticky error flag.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addrD,
  input  logic [4:0]       rs2_addrD,
  input  logic [4:0]       rs1_addrE,
  input  logic [4:0]       rs2_addrE,
  input  logic [4:0]       rdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic [4:0]       rdM,
  input  logic             RegWriteM,
  input  logic [4:0]       rdW,
  input  logic             RegWriteW,
  input  logic             mem_req_M,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt,
`endif
  output logic             mem_err
);

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int unsigned WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  // Reject parameter values the wait logic cannot honour.
  if (MEM_TIMEOUT < 2) begin : g_bad_timeout
    $error("hazard_ctrl: MEM_TIMEOUT must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic ms_c;
  logic lu_c;

  // Forwarding source select for one EX operand; MEM beats WB, x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == src)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Load in EX whose destination is read by the instruction in ID.
  assign lu_c = MemReadE && (rdE != 5'd0) &&
                ((rdE == rs1_addrD) || (rdE == rs2_addrD));

  // Memory stall: outstanding access not yet ready, except in the release cycle.
  assign ms_c = mem_req_M && !mem_ready &&
                ((state_q == S_RUN) || (state_q == S_WAIT));

  // State register: FSM state, wait counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state logic for the memory wait FSM and its timeout counter.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      S_RUN: begin
        if (mem_req_M && !mem_ready) begin
          state_d    = S_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_LAST) begin
          // Abandon the access; the next cycle lets it drain out of MEM.
          state_d    = S_RELEASE;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      S_RELEASE: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output logic: prioritised stall/flush plus forwarding, all zero in reset.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      ForwardAE = fwd_sel(rs1_addrE, rdM, RegWriteM, rdW, RegWriteW);
      ForwardBE = fwd_sel(rs2_addrE, rdM, RegWriteM, rdW, RegWriteW);
      if (ms_c) begin
        // Freeze the whole front of the pipe; EX hazards are re-evaluated later.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        // Redirect squashes ID, which also removes any load-use dependency.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lu_c) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  // Counter increments follow the same priority as the stall/flush outputs.
  always_comb begin
    lu_cnt_d      = lu_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (ms_c) begin
      memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
    end else if (PCSrcE) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (lu_c) begin
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    end
  end

  // Performance counter registers, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt_q      <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      lu_cnt_q      <= lu_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign lu_cnt      = lu_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, hand-written memory-wait,
// timeout and async-reset sequences, then random stimulus against a model.
module tb_hazard_ctrl;

  localparam int unsigned T     = 4;
  localparam int unsigned CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rdE, rdM, rdW;
  logic       MemReadE, PCSrcE, RegWriteM, RegWriteW, mem_req_M, mem_ready;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_cnt, flush_cnt, memwait_cnt;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD),
    .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE),
    .rdE(rdE), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .rdM(rdM), .RegWriteM(RegWriteM), .rdW(rdW), .RegWriteW(RegWriteW),
    .mem_req_M(mem_req_M), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_EN
    .lu_cnt(lu_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt),
`endif
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
    logic       mr, pc;
    logic [4:0] rdM;
    logic       rwM;
    logic [4:0] rdW;
    logic       rwW, req, rdy;
  } in_t;

  // Order: StallF StallD StallE StallM FlushD FlushE FlushW | FwdA | FwdB | mem_err
  typedef struct packed {
    logic       sF, sD, sE, sM, fD, fE, fW;
    logic [1:0] fa, fb;
    logic       err;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: stall cycles elapsed in the current wait, release flag.
  int m_wait;
  bit m_rel, m_err;
  int m_lu, m_fl, m_mw;

  function automatic in_t mk(int rs1D, int rs2D, int rs1E, int rs2E, int rd_e,
                             int mr, int pc, int rd_m, int rwM, int rd_w,
                             int rwW, int req, int rdy);
    in_t v;
    v.rs1D = 5'(rs1D); v.rs2D = 5'(rs2D); v.rs1E = 5'(rs1E); v.rs2E = 5'(rs2E);
    v.rdE = 5'(rd_e); v.mr = 1'(mr); v.pc = 1'(pc);
    v.rdM = 5'(rd_m); v.rwM = 1'(rwM); v.rdW = 5'(rd_w); v.rwW = 1'(rwW);
    v.req = 1'(req); v.rdy = 1'(rdy);
    return v;
  endfunction

  task automatic apply(input in_t v);
    rs1_addrD = v.rs1D; rs2_addrD = v.rs2D; rs1_addrE = v.rs1E; rs2_addrE = v.rs2E;
    rdE = v.rdE; MemReadE = v.mr; PCSrcE = v.pc;
    rdM = v.rdM; RegWriteM = v.rwM; rdW = v.rdW; RegWriteW = v.rwW;
    mem_req_M = v.req; mem_ready = v.rdy;
  endtask

  function automatic out_t get_out();
    return out_t'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                   ForwardAE, ForwardBE, mem_err});
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = get_out();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] src, input in_t v);
    if (v.rwM && v.rdM != 0 && v.rdM == src) return 2'b10;
    if (v.rwW && v.rdW != 0 && v.rdW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_ms(input in_t v);
    return v.req && !v.rdy && !m_rel;
  endfunction

  function automatic bit m_lu_hit(input in_t v);
    return v.mr && v.rdE != 0 && (v.rdE == v.rs1D || v.rdE == v.rs2D);
  endfunction

  function automatic out_t model_out(input in_t v);
    out_t o;
    o = '0;
    if (m_ms(v)) begin
      o.sF = 1; o.sD = 1; o.sE = 1; o.sM = 1; o.fW = 1;
    end else if (v.pc) begin
      o.fD = 1; o.fE = 1;
    end else if (m_lu_hit(v)) begin
      o.sF = 1; o.sD = 1; o.fE = 1;
    end
    o.fa  = m_fwd(v.rs1E, v);
    o.fb  = m_fwd(v.rs2E, v);
    o.err = m_err;
    return o;
  endfunction

  // Advance the model by one clock: counts stalled cycles of the current access.
  task automatic model_tick(input in_t v);
    if (m_ms(v)) m_mw++;
    else if (v.pc) m_fl++;
    else if (m_lu_hit(v)) m_lu++;
    if (m_rel) begin
      m_rel = 0;
    end else if (m_wait == 0) begin
      if (v.req && !v.rdy) m_wait = 1;
    end else if (v.rdy) begin
      m_wait = 0;
    end else if (m_wait == int'(T) - 1) begin
      m_wait = 0; m_rel = 1; m_err = 1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_rel = 0; m_err = 0;
    m_lu = 0; m_fl = 0; m_mw = 0;
  endtask

  task automatic run_cycle(input string name, input in_t v, input bit use_model,
                           input out_t exp);
    out_t e;
    @(negedge clk);
    apply(v);
    #1;
    e = use_model ? model_out(v) : exp;
    check(name, e);
    model_tick(v);
  endtask

`ifdef HAZARD_PERF_EN
  task automatic check_cnt(input string name, input logic [CNT_W-1:0] act, input int exp);
    checks++;
    if (act !== CNT_W'(exp)) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, CNT_W'(exp));
    end
  endtask
`endif

  vec_t tab[$];
  in_t  idle, v;
  out_t stall_o, none_o;

  initial begin
    idle    = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
    stall_o = 12'b1111001_00_00_0;
    none_o  = '0;
    model_reset();

    tab.push_back('{"fwd_mem",      mk(0,0,5,7,0,0,0,5,1,5,1,0,0), 12'b0000000_10_00_0});
    tab.push_back('{"fwd_wb",       mk(0,0,5,7,0,0,0,5,0,5,1,0,0), 12'b0000000_01_00_0});
    tab.push_back('{"fwd_rd_zero",  mk(0,0,5,7,0,0,0,0,1,0,1,0,0), 12'b0000000_00_00_0});
    tab.push_back('{"fwd_x0_src",   mk(0,0,0,0,0,0,0,0,1,0,1,0,0), 12'b0000000_00_00_0});
    tab.push_back('{"fwd_split",    mk(0,0,3,4,0,0,0,3,1,4,1,0,0), 12'b0000000_10_01_0});
    tab.push_back('{"fwd_mem_prio", mk(0,0,9,9,0,0,0,9,1,9,1,0,0), 12'b0000000_10_10_0});
    tab.push_back('{"lu_rs2",       mk(1,3,0,0,3,1,0,0,0,0,0,0,0), 12'b1100010_00_00_0});
    tab.push_back('{"lu_x0",        mk(0,0,0,0,0,1,0,0,0,0,0,0,0), 12'b0000000_00_00_0});
    tab.push_back('{"lu_rs1",       mk(7,2,0,0,7,1,0,0,0,0,0,0,0), 12'b1100010_00_00_0});
    tab.push_back('{"lu_one_bubble",mk(7,2,0,0,7,0,0,0,0,0,0,0,0), 12'b0000000_00_00_0});
    tab.push_back('{"lu_and_br",    mk(1,3,0,0,3,1,1,0,0,0,0,0,0), 12'b0000110_00_00_0});
    tab.push_back('{"br_only",      mk(0,0,0,0,0,0,1,0,0,0,0,0,0), 12'b0000110_00_00_0});
    tab.push_back('{"zero_wait",    mk(0,0,0,0,0,0,0,0,0,0,0,1,1), 12'b0000000_00_00_0});

    // Reset with every hazard condition active: all outputs must be zero.
    rst = 1'b1;
    apply(mk(3,3,5,5,3,1,1,5,1,5,1,1,0));
    #1;
    check("reset_outputs", none_o);
    apply(idle);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tab[k]) run_cycle(tab[k].name, tab[k].i, 1'b0, tab[k].o);

    // Memory wait with ready on the 4th cycle and a redirect held throughout.
    v = mk(0,0,0,0,0,0,1,0,0,0,0,1,0);
    for (int c = 0; c < 3; c++) run_cycle($sformatf("memwait_c%0d", c), v, 1'b0, stall_o);
    v.rdy = 1'b1;
    run_cycle("memwait_ready", v, 1'b0, 12'b0000110_00_00_0);
    run_cycle("memwait_after", idle, 1'b0, none_o);

    // Timeout: ready held low; T stall cycles, then a release cycle, error sticks.
    v = mk(0,0,0,0,0,0,0,0,0,0,0,1,0);
    for (int c = 0; c < int'(T); c++) run_cycle($sformatf("timeout_c%0d", c), v, 1'b0, stall_o);
    run_cycle("timeout_release", v, 1'b0, 12'b0000000_00_00_1);
    run_cycle("timeout_restall", v, 1'b0, 12'b1111001_00_00_1);
    run_cycle("timeout_wait2", v, 1'b0, 12'b1111001_00_00_1);

    // Asynchronous reset in the middle of a wait clears everything at once.
    @(negedge clk);
    #2;
    rst = 1'b1;
    apply(mk(1,3,5,5,3,1,1,5,1,5,1,1,0));
    #1;
    check("async_reset_mid_wait", none_o);
    model_reset();
    apply(idle);
    @(negedge clk);
    rst = 1'b0;
    run_cycle("post_reset_ready", mk(0,0,0,0,0,0,0,0,0,0,0,1,1), 1'b0, none_o);

    // Random traffic: small register range to make matches frequent.
    for (int n = 0; n < 3000; n++) begin
      v.rs1D = 5'($urandom_range(0, 3));
      v.rs2D = 5'($urandom_range(0, 3));
      v.rs1E = 5'($urandom_range(0, 3));
      v.rs2E = 5'($urandom_range(0, 3));
      v.rdE  = 5'($urandom_range(0, 3));
      v.rdM  = 5'($urandom_range(0, 3));
      v.rdW  = 5'($urandom_range(0, 3));
      v.mr   = 1'($urandom_range(0, 1));
      v.pc   = 1'($urandom_range(0, 3) == 0);
      v.rwM  = 1'($urandom_range(0, 1));
      v.rwW  = 1'($urandom_range(0, 1));
      v.req  = (m_wait != 0) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      v.rdy  = 1'($urandom_range(0, 3) == 0);
      run_cycle("random", v, 1'b1, none_o);
    end

`ifdef HAZARD_PERF_EN
    #1;
    check_cnt("lu_cnt", lu_cnt, m_lu);
    check_cnt("flush_cnt", flush_cnt, m_fl);
    check_cnt("memwait_cnt", memwait_cnt, m_mw);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
